// File: rtl/mem_write_manager.sv
// Store write manager: turns a byte/half/word store into one or two
// lane-aligned write beats, splitting word-boundary crossings when allowed.
module mem_write_manager #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t      r_state, w_state_next;
  logic        r_mem_we, w_mem_we_next;
  logic [29:0] r_mem_addr, w_mem_addr_next;
  logic [31:0] r_mem_wdata, w_mem_wdata_next;
  logic [3:0]  r_mem_be, w_mem_be_next;
  logic        r_done, w_done_next;
  logic        r_err, w_err_next;
  logic        r_span, w_span_next;
  logic [29:0] r_b1_addr, w_b1_addr_next;
  logic [31:0] r_b1_data, w_b1_data_next;
  logic [3:0]  r_b1_be, w_b1_be_next;

  logic [1:0]  w_off;
  logic [3:0]  w_size_mask;
  logic [7:0]  w_be_wide;
  logic [63:0] w_data_wide;
  logic [31:0] w_lane_lo, w_lane_hi;
  logic        w_span, w_reject;

  // Shift the request into an 8-lane window: lanes 0-3 form beat 0, 4-7 beat 1.
  assign w_off       = addr[1:0];
  assign w_size_mask = (size == 2'b00) ? 4'b0001 :
                       (size == 2'b01) ? 4'b0011 : 4'b1111;
  assign w_be_wide   = {4'b0000, w_size_mask} << w_off;
  assign w_data_wide = {32'h0, wdata} << {w_off, 3'b000};
  assign w_span      = |w_be_wide[7:4];
  assign w_reject    = (size == 2'b11) || (w_span && !ALLOW_MISALIGNED);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_lo[8*gi +: 8] = {8{w_be_wide[gi]}};
      assign w_lane_hi[8*gi +: 8] = {8{w_be_wide[gi+4]}};
    end
  endgenerate

  always_comb begin
    w_state_next     = r_state;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_be_next    = r_mem_be;
    w_done_next      = 1'b0;
    w_err_next       = 1'b0;
    w_span_next      = r_span;
    w_b1_addr_next   = r_b1_addr;
    w_b1_data_next   = r_b1_data;
    w_b1_be_next     = r_b1_be;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_reject) begin
            w_err_next = 1'b1;
          end else begin
            w_state_next     = BEAT0;
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = addr[31:2];
            w_mem_be_next    = w_be_wide[3:0];
            w_mem_wdata_next = w_data_wide[31:0] & w_lane_lo;
            w_span_next      = w_span;
            w_b1_addr_next   = addr[31:2] + 30'd1;
            w_b1_be_next     = w_be_wide[7:4];
            w_b1_data_next   = w_data_wide[63:32] & w_lane_hi;
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          if (r_span) begin
            w_state_next     = BEAT1;
            w_mem_addr_next  = r_b1_addr;
            w_mem_be_next    = r_b1_be;
            w_mem_wdata_next = r_b1_data;
          end else begin
            w_state_next  = IDLE;
            w_mem_we_next = 1'b0;
            w_done_next   = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ack) begin
          w_state_next  = IDLE;
          w_mem_we_next = 1'b0;
          w_done_next   = 1'b1;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_mem_we_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_span      <= 1'b0;
      r_b1_addr   <= '0;
      r_b1_data   <= '0;
      r_b1_be     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_be    <= w_mem_be_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      r_span      <= w_span_next;
      r_b1_addr   <= w_b1_addr_next;
      r_b1_data   <= w_b1_data_next;
      r_b1_be     <= w_b1_be_next;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign done      = r_done;
  assign err       = r_err;

endmodule
